// File: rtl/seg_scan_if.sv
// Display-side bundle between the time-keeping logic and the seven-segment scan driver.
// master drives control and digit data; slave produces the pin-level scan outputs.
interface seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 9
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits_bcd;
  logic                    load;
  logic                    lz_en;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    err_clr;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;
  logic                    err_flag;

  modport master (
    output en, digits_bcd, load, lz_en, blank_mask, blink_mask, err_clr,
    input  seg, dig_sel, frame_done, err_flag
  );

  modport slave (
    input  en, digits_bcd, load, lz_en, blank_mask, blink_mask, err_clr,
    output seg, dig_sel, frame_done, err_flag
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: tear-free frame snapshots, dead time,
// leading-zero suppression, blanking/blinking, invalid-code flag and pin polarity.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 9,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b0
) (
  input logic      clk,
  input logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned DW = 4 * NUM_DIGITS;

  localparam logic [6:0]            SEG_INV = ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_INV = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic                  blink_q, blink_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic [DW-1:0]         display_q, display_d;
  logic                  err_q, err_d;
  logic                  frame_done_q, frame_done_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;

  logic [3:0] cur_digit;
  logic       lz_blank;
  logic       blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b1111101;
      4'd1:    return 7'b1100000;
      4'd2:    return 7'b0110111;
      4'd3:    return 7'b1100111;
      4'd4:    return 7'b1101010;
      4'd5:    return 7'b1001111;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1100001;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101011;
      default: return 7'b0000010;
    endcase
  endfunction

  // Blank decision for the digit currently addressed; LZ looks at this digit and all above it
  always_comb begin
    cur_digit = display_q[{idx_q, 2'b00} +: 4];
    lz_blank  = bus.lz_en && (idx_q != '0) && ((display_q >> {idx_q, 2'b00}) == '0);
    blank     = bus.blank_mask[idx_q] | (blink_q & bus.blink_mask[idx_q]) | lz_blank;
  end

  // Next-state and registered-output computation
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    frame_d      = frame_q;
    blink_d      = blink_q;
    display_d    = display_q;
    pending_d    = bus.load ? bus.digits_bcd : pending_q;
    err_d        = err_q & ~bus.err_clr;
    frame_done_d = 1'b0;
    seg_d        = SEG_INV;
    dig_sel_d    = DIG_INV;

    if (bus.en) begin
      seg_d     = (blank ? 7'h00 : seg_decode(cur_digit)) ^ SEG_INV;
      dig_sel_d = ((presc_q == '0) ? '0 : (NUM_DIGITS'(1) << idx_q)) ^ DIG_INV;
      if (!blank && (cur_digit > 4'd9)) begin
        err_d = 1'b1;
      end

      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_d = '0;
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          // Frame boundary: the only point where the displayed snapshot may change
          idx_d        = '0;
          frame_done_d = 1'b1;
          display_d    = pending_q;
          if (frame_q == FW'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            blink_d = ~blink_q;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frame_q      <= '0;
      blink_q      <= 1'b0;
      pending_q    <= '0;
      display_q    <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_INV;
      dig_sel_q    <= DIG_INV;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      pending_q    <= pending_d;
      display_q    <= display_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_flag   = err_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: timeline model checked every cycle against an active-high
// and an active-low instance, plus hand-computed slot expectations.
module tb_seg_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned BF = 2;
  localparam int unsigned FL = SD * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  seg_scan_if #(.NUM_DIGITS(N)) bus0 ();
  seg_scan_if #(.NUM_DIGITS(N)) bus1 ();

  assign bus0.en = en;            assign bus1.en = en;
  assign bus0.digits_bcd = digits; assign bus1.digits_bcd = digits;
  assign bus0.load = load;        assign bus1.load = load;
  assign bus0.lz_en = lz_en;      assign bus1.lz_en = lz_en;
  assign bus0.blank_mask = blank_mask; assign bus1.blank_mask = blank_mask;
  assign bus0.blink_mask = blink_mask; assign bus1.blink_mask = blink_mask;
  assign bus0.err_clr = err_clr;  assign bus1.err_clr = err_clr;

  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1))
    u_inv (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111101;  4'd1: return 7'b1100000;
      4'd2: return 7'b0110111;  4'd3: return 7'b1100111;
      4'd4: return 7'b1101010;  4'd5: return 7'b1001111;
      4'd6: return 7'b1011111;  4'd7: return 7'b1100001;
      4'd8: return 7'b1111111;  4'd9: return 7'b1101011;
      default: return 7'b0000010;
    endcase
  endfunction

  // Model: position in the scan derived from the count of enabled cycles since reset
  int unsigned t = 0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_disp = '0;
  logic        m_err = 1'b0;
  logic [6:0]  e_seg = '0;
  logic [3:0]  e_dig = '0;
  logic        e_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; m_pend = '0; m_disp = '0; m_err = 1'b0;
      e_seg = '0; e_dig = '0; e_fd = 1'b0;
    end else begin
      int unsigned pr, ix, fr;
      logic [3:0] d;
      logic bl;
      pr = t % SD;
      ix = (t / SD) % N;
      fr = t / FL;
      d  = m_disp[4*ix +: 4];
      bl = blank_mask[ix] | (((fr / BF) % 2 == 1) && blink_mask[ix])
         | (lz_en && ix > 0 && ((m_disp >> (4*ix)) == 16'h0));
      if (en) begin
        e_seg = bl ? 7'h00 : seg_ref(d);
        e_dig = (pr == 0) ? 4'h0 : 4'(1 << ix);
        e_fd  = (t % FL) == FL - 1;
        m_err = (!bl && d > 4'd9) | (m_err & !err_clr);
        t++;
        if (t % FL == 0) m_disp = m_pend;
      end else begin
        e_seg = '0; e_dig = '0; e_fd = 1'b0;
        m_err = m_err & !err_clr;
      end
      if (load) m_pend = digits;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("seg", 32'(bus0.seg), 32'(e_seg));
      chk("dig_sel", 32'(bus0.dig_sel), 32'(e_dig));
      chk("frame_done", 32'(bus0.frame_done), 32'(e_fd));
      chk("err_flag", 32'(bus0.err_flag), 32'(m_err));
      chk("seg_al", 32'(bus1.seg), 32'(e_seg ^ 7'h7f));
      chk("dig_sel_al", 32'(bus1.dig_sel), 32'(e_dig ^ 4'hf));
      chk("err_flag_al", 32'(bus1.err_flag), 32'(m_err));
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.frame_done && n < 200);
    chk("wait_frame", 32'(bus0.frame_done), 32'd1);
  endtask

  task automatic wait_slot(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus0.dig_sel !== 4'(1 << i) && n < 200);
    chk("wait_slot", 32'(bus0.dig_sel), 32'(1 << i));
  endtask

  task automatic load_show(input logic [15:0] v);
    @(negedge clk);
    digits = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    wait_frame();
  endtask

  initial begin
    int n;
    int vis;
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(bus0.seg), 32'h0);
    chk("rst_dig", 32'(bus0.dig_sel), 32'h0);
    chk("rst_fd", 32'(bus0.frame_done), 32'h0);
    chk("rst_err", 32'(bus0.err_flag), 32'h0);
    chk("rst_seg_al", 32'(bus1.seg), 32'h7f);
    chk("rst_dig_al", 32'(bus1.dig_sel), 32'hf);
    rst_n = 1'b1;
    en = 1'b1;

    // Basic scan of 1234
    load_show(16'h1234);
    wait_slot(0); chk("s1_d0", 32'(bus0.seg), 32'b1101010);
    wait_slot(1); chk("s1_d1", 32'(bus0.seg), 32'b1100111);
    wait_slot(2); chk("s1_d2", 32'(bus0.seg), 32'b0110111);
    wait_slot(3); chk("s1_d3", 32'(bus0.seg), 32'b1100000);
    wait_frame();
    n = 0;
    do begin @(negedge clk); n++; end while (!bus0.frame_done && n < 100);
    chk("frame_period", 32'(n), 32'd16);

    // Snapshot: mid-frame load, then load in the boundary cycle
    repeat (6) @(negedge clk);
    digits = 16'h5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    digits = 16'h9999; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("s3_boundary", 32'(bus0.frame_done), 32'd1);
    wait_slot(0); chk("s3_next", 32'(bus0.seg), 32'b1111111);
    wait_frame();
    wait_slot(0); chk("s3_follow", 32'(bus0.seg), 32'b1101011);

    // Reset mid-slot of digit 2
    wait_slot(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(bus0.seg), 32'h0);
    chk("arst_dig", 32'(bus0.dig_sel), 32'h0);
    chk("arst_dig_al", 32'(bus1.dig_sel), 32'hf);
    @(negedge clk);
    rst_n = 1'b1;
    wait_slot(0); chk("s2_first", 32'(bus0.seg), 32'b1111101);

    // Leading-zero suppression
    lz_en = 1'b1;
    load_show(16'h0050);
    wait_slot(0); chk("lz_d0", 32'(bus0.seg), 32'b1111101);
    wait_slot(1); chk("lz_d1", 32'(bus0.seg), 32'b1001111);
    wait_slot(2); chk("lz_d2", 32'(bus0.seg), 32'h0);
    wait_slot(3); chk("lz_d3", 32'(bus0.seg), 32'h0);
    load_show(16'h0000);
    wait_slot(0); chk("lz0_d0", 32'(bus0.seg), 32'b1111101);
    wait_slot(1); chk("lz0_d1", 32'(bus0.seg), 32'h0);
    lz_en = 1'b0;

    // Blink on digit 1: shown in exactly half of 8 consecutive frames
    blink_mask = 4'b0010;
    load_show(16'h1234);
    vis = 0;
    for (int k = 0; k < 8; k++) begin
      wait_frame();
      wait_slot(1);
      if (bus0.seg != 7'h0) vis++;
    end
    chk("blink_frames", 32'(vis), 32'd4);
    blink_mask = 4'b0000;

    // Scan disable holds and blanks
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("en0_dig", 32'(bus0.dig_sel), 32'h0);
    en = 1'b1;
    repeat (40) @(negedge clk);

    // Invalid code: blanked first, then shown, then cleared
    blank_mask = 4'b0001;
    load_show(16'h123A);
    chk("blank_inv_err", 32'(bus0.err_flag), 32'h0);
    blank_mask = 4'b0000;
    wait_slot(0); chk("inv_seg", 32'(bus0.seg), 32'b0000010);
    chk("inv_err", 32'(bus0.err_flag), 32'h1);
    load_show(16'h1233);
    chk("err_held", 32'(bus0.err_flag), 32'h1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(bus0.err_flag), 32'h0);
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
